// File: rtl/hazard_detection_unit_if.sv
// Pipeline-side signal bundle for the hazard detection unit.
// The master is the pipeline that drives stage info; the slave is the interlock.
interface hazard_detection_unit_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   ID_EX_MemRead;
    logic                   ID_EX_RegWrite;
    logic [4:0]             ID_EX_WriteReg;
    logic                   ID_EX_MduStart;
    logic                   EX_MEM_MemRead;
    logic [4:0]             EX_MEM_WriteReg;
    logic [4:0]             IF_ID_RegisterRs;
    logic [4:0]             IF_ID_RegisterRt;
    logic                   IF_ID_UsesRt;
    logic                   ID_Branch;
    logic                   ID_BranchTaken;
    logic                   ID_Jump;
    logic                   IF_ID_MduOp;
    logic                   PCWrite;
    logic                   IF_ID_Write;
    logic                   ID_EX_Bubble;
    logic                   IF_ID_Flush;
    logic                   mdu_busy;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output ID_EX_MemRead, ID_EX_RegWrite, ID_EX_WriteReg, ID_EX_MduStart,
               EX_MEM_MemRead, EX_MEM_WriteReg, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump, IF_ID_MduOp,
        input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, mdu_busy, stall_count
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegWrite, ID_EX_WriteReg, ID_EX_MduStart,
               EX_MEM_MemRead, EX_MEM_WriteReg, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump, IF_ID_MduOp,
        output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, mdu_busy, stall_count
    );
endinterface

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use, ID-stage branch
// operand and MDU interlocks, plus an MDU busy counter and a stall performance counter.
module hazard_detection_unit #(
    parameter int MDU_LATENCY = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_detection_unit_if.slave  hz
);
    logic [3:0]             mdu_cnt_q, mdu_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   load_use, br_haz, mdu_haz, stall, redirect;

    // Register $0 is hardwired to zero, so it never carries a real dependency.
    function automatic logic dep(input logic [4:0] x, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic uses_rt);
        return (x != 5'd0) && ((x == rs) || (uses_rt && (x == rt)));
    endfunction

    always_comb begin
        load_use = hz.ID_EX_MemRead &&
                   dep(hz.ID_EX_WriteReg, hz.IF_ID_RegisterRs, hz.IF_ID_RegisterRt, hz.IF_ID_UsesRt);
        br_haz   = hz.ID_Branch &&
                   ((hz.ID_EX_RegWrite &&
                     dep(hz.ID_EX_WriteReg, hz.IF_ID_RegisterRs, hz.IF_ID_RegisterRt, hz.IF_ID_UsesRt)) ||
                    (hz.EX_MEM_MemRead &&
                     dep(hz.EX_MEM_WriteReg, hz.IF_ID_RegisterRs, hz.IF_ID_RegisterRt, hz.IF_ID_UsesRt)));
        mdu_haz  = hz.IF_ID_MduOp && (hz.ID_EX_MduStart || (mdu_cnt_q != 4'd0));
        stall    = load_use || br_haz || mdu_haz;
        redirect = (hz.ID_Branch && hz.ID_BranchTaken) || hz.ID_Jump;
    end

    // The counter keeps running through stalls: the MDU itself never freezes.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (hz.ID_EX_MduStart)
            mdu_cnt_d = 4'(MDU_LATENCY - 1);
        else if (mdu_cnt_q != 4'd0)
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(stall);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_cnt_q   <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Stall outranks a redirect; the branch is re-resolved once the stall drops.
    always_comb begin
        hz.PCWrite      = 1'b1;
        hz.IF_ID_Write  = 1'b1;
        hz.ID_EX_Bubble = 1'b0;
        hz.IF_ID_Flush  = 1'b0;
        if (reset) begin
            hz.PCWrite      = 1'b0;
            hz.IF_ID_Write  = 1'b0;
            hz.ID_EX_Bubble = 1'b1;
            hz.IF_ID_Flush  = 1'b1;
        end else if (stall) begin
            hz.PCWrite      = 1'b0;
            hz.IF_ID_Write  = 1'b0;
            hz.ID_EX_Bubble = 1'b1;
        end else if (redirect) begin
            hz.IF_ID_Flush  = 1'b1;
        end
        hz.mdu_busy    = !reset && (mdu_cnt_q != 4'd0);
        hz.stall_count = stall_cnt_q;
    end
endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Interlock and stall controller for the 5-stage MIPS pipeline. It is the stall-side counterpart of the forwarding path.
- Detects hazards that forwarding cannot resolve: load-use, branch operands compared in ID, and MFHI/MFLO or back-to-back MULT/DIV against a multi-cycle MDU.
- Drives PC/IF_ID write enables, ID_EX bubble insertion and IF_ID flush on taken branches/jumps.
- Holds an MDU busy counter and a stall performance counter.

Parameters:
- MDU_LATENCY, 4, cycles the MDU is busy, counted from the cycle MULT/DIV is in EX (legal range 1..15).
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- ID_EX_RegWrite  input  1  instruction in EX writes a register.
- ID_EX_WriteReg  input  5  destination register of the instruction in EX.
- ID_EX_MduStart  input  1  instruction in EX is MULT/DIV.
- EX_MEM_MemRead  input  1  instruction in MEM is a load.
- EX_MEM_WriteReg  input  5  destination register of the instruction in MEM.
- IF_ID_RegisterRs  input  5  rs of the instruction in ID.
- IF_ID_RegisterRt  input  5  rt of the instruction in ID.
- IF_ID_UsesRt  input  1  instruction in ID reads rt as a source.
- ID_Branch  input  1  instruction in ID is a conditional branch (compared in ID).
- ID_BranchTaken  input  1  branch comparison result in ID.
- ID_Jump  input  1  instruction in ID is J/JAL/JR.
- IF_ID_MduOp  input  1  instruction in ID is MULT/DIV/MFHI/MFLO.
- PCWrite  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register update enable.
- ID_EX_Bubble  output  1  zero the ID/EX control fields.
- IF_ID_Flush  output  1  replace the IF/ID contents with a NOP.
- mdu_busy  output  1  the MDU counter is nonzero.
- stall_count  output  STALL_CNT_W  total stall cycles since reset; wraps.

Behaviour:
- Register-match terms. Each term requires the named register to be nonzero.
  - rs_m(X) = (X == IF_ID_RegisterRs).
  - rt_m(X) = IF_ID_UsesRt && (X == IF_ID_RegisterRt).
  - dep(X) = rs_m(X) || rt_m(X).
- load_use = ID_EX_MemRead && dep(ID_EX_WriteReg).
- br_haz = ID_Branch && one of:
  - ID_EX_RegWrite && dep(ID_EX_WriteReg), or
  - EX_MEM_MemRead && dep(EX_MEM_WriteReg).
  - For a branch on a load result, the load in EX gives 2 stall cycles and the load in MEM gives 1. This emerges from re-evaluation each cycle.
- mdu_haz = IF_ID_MduOp && (ID_EX_MduStart || mdu_cnt != 0).
- stall = load_use || br_haz || mdu_haz.
- MDU counter (4-bit mdu_cnt), evaluated each cycle in this priority order:
  - reset: load 0.
  - ID_EX_MduStart: load MDU_LATENCY-1.
  - mdu_cnt != 0: decrement.
  - otherwise: hold.
  - The counter runs independently of stall.
  - The net effect is that a dependent MDU op in ID stalls exactly MDU_LATENCY cycles from the MULT-in-EX cycle.
  - A start arriving while the counter is nonzero reloads it (not expected in legal flow).
- mdu_busy = (mdu_cnt != 0). It is registered-state derived.
- Outputs are combinational from inputs and state:
  - During stall: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
  - Else if (ID_Branch && ID_BranchTaken) || ID_Jump: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=1, for exactly one cycle per redirect.
  - Else: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0.
- Simultaneous stall and taken branch/jump: stall wins and there is no flush. The branch is re-evaluated when the stall clears.
- stall_count:
  - Increments by 1 on each rising edge where stall=1 and reset=0.
  - Wraps at 2^STALL_CNT_W.
- Reset, when asserted on the rising edge:
  - mdu_cnt=0 and stall_count=0.
  - While reset=1, outputs are forced: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=1, mdu_busy reflects the cleared counter.
  - A reset asserted mid-stall or mid-MDU aborts it. The first cycle after reset deasserts behaves as a cleared state.
- Register $0 never creates a hazard.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_WriteReg=8, IF_ID_RegisterRs=8 -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for 1 cycle; stall_count 0->1. The same case with WriteReg=0 -> no stall.
- Branch dependencies:
  - ID_Branch=1, Rt=9, IF_ID_UsesRt=1, ID_EX_RegWrite=1, ID_EX_WriteReg=9 -> 1 stall.
  - A load to 9 in EX, then in MEM -> 2 consecutive stall cycles, stall_count +2.
  - rt match with IF_ID_UsesRt=0 -> no stall.
- Taken branch, no dependency: ID_Branch=1, ID_BranchTaken=1 -> IF_ID_Flush=1 for one cycle, PCWrite=1. ID_Jump=1 gives the same result.
- MDU, MDU_LATENCY=4: ID_EX_MduStart=1 at cycle t with IF_ID_MduOp=1 -> stall at t..t+3 (4 cycles), mdu_busy=1 at t+1..t+3 and 0 at t+4; MFLO advances at t+4.
- Stall plus taken branch in the same cycle -> IF_ID_Flush=0 while stalled; flush asserts on the first non-stall cycle.
- Reset during an MDU count (mdu_cnt=2) -> next cycle mdu_cnt=0, stall_count=0, no residual stall after reset deasserts.
